// File: rtl/face_box_ctrl.sv
// Frame-level controller for the face bounding-box detector: frame tracking,
// per-frame statistics clear, end-of-frame box validation/debounce and LCD border overlay.
module face_box_ctrl #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int MIN_SIZE    = 16,
    parameter int LOST_FRAMES = 4,
    parameter int LINE_W      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic [9:0] det_x_min,
    input  logic [9:0] det_x_max,
    input  logic [9:0] det_y_min,
    input  logic [9:0] det_y_max,
    input  logic [9:0] lcd_x,
    input  logic [9:0] lcd_y,
    output logic       stat_clear,
    output logic [9:0] box_x_min,
    output logic [9:0] box_x_max,
    output logic [9:0] box_y_min,
    output logic [9:0] box_y_max,
    output logic       box_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       box_hit
);

    if (IMG_W < 1 || IMG_W > 1024 || IMG_H < 1 || IMG_H > 1023 ||
        LOST_FRAMES < 1 || LOST_FRAMES > 15 || LINE_W < 1 || LINE_W > 1023 ||
        MIN_SIZE < 0 || MIN_SIZE > 1024) begin : g_param_check
        $error("face_box_ctrl: parameter out of range");
    end

    localparam logic [9:0]  IMG_H_L = 10'(IMG_H);
    localparam logic [10:0] MIN_L   = 11'(MIN_SIZE);
    localparam logic [3:0]  LOST_L  = 4'(LOST_FRAMES);
    localparam logic [10:0] LW_L    = 11'(LINE_W);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        SETTLE1,
        SETTLE2,
        EVAL
    } state_t;

    state_t     state_q, state_d;
    logic       vs_q, hs_q;
    logic [9:0] line_q, line_d;
    logic [3:0] miss_q, miss_d;
    logic       stat_clear_q, stat_clear_d;
    logic [9:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       hit_q, hit_d;

    logic        sof, eof, href_fall;
    logic        order_ok, size_ok;
    logic [10:0] width, height;
    logic [3:0]  miss_inc;

    assign sof       = per_frame_vsync & ~vs_q;
    assign eof       = ~per_frame_vsync & vs_q;
    assign href_fall = ~per_frame_href & hs_q;

    // Size is only meaningful once both axes are ordered, so it is gated by order_ok.
    assign order_ok = (det_x_max >= det_x_min) && (det_y_max >= det_y_min);
    assign width    = {1'b0, det_x_max} - {1'b0, det_x_min} + 11'd1;
    assign height   = {1'b0, det_y_max} - {1'b0, det_y_min} + 11'd1;
    assign size_ok  = order_ok && (width >= MIN_L) && (height >= MIN_L);
    assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        miss_d       = miss_q;
        stat_clear_d = 1'b0;
        bx0_d        = bx0_q;
        bx1_d        = bx1_q;
        by0_d        = by0_q;
        by1_d        = by1_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            line_d  = 10'd0;
            miss_d  = 4'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_SOF;
                WAIT_SOF: begin
                    if (sof) begin
                        state_d      = ACTIVE;
                        stat_clear_d = 1'b1;
                        line_d       = 10'd0;
                    end
                end
                ACTIVE: begin
                    if (href_fall && (line_q != 10'h3FF)) begin
                        line_d = line_q + 10'd1;
                    end
                    if (eof) begin
                        state_d = SETTLE1;
                    end
                end
                SETTLE1: state_d = SETTLE2;
                SETTLE2: state_d = EVAL;
                EVAL: begin
                    state_d = WAIT_SOF;
                    if (line_q != IMG_H_L) begin
                        err_d = 1'b1;
                    end else if (size_ok) begin
                        bx0_d   = det_x_min;
                        bx1_d   = det_x_max;
                        by0_d   = det_y_min;
                        by1_d   = det_y_max;
                        valid_d = 1'b1;
                        miss_d  = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc >= LOST_L) begin
                            valid_d = 1'b0;
                        end
                        done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Border test in 11 bits; "x > max - LINE_W" is written as "x + LINE_W > max" to avoid wrap.
    logic [10:0] lx, ly;
    logic        in_x, in_y, edge_x, edge_y;

    assign lx     = {1'b0, lcd_x};
    assign ly     = {1'b0, lcd_y};
    assign in_x   = (lx >= {1'b0, bx0_q}) && (lx <= {1'b0, bx1_q});
    assign in_y   = (ly >= {1'b0, by0_q}) && (ly <= {1'b0, by1_q});
    assign edge_x = (lx < ({1'b0, bx0_q} + LW_L)) || ((lx + LW_L) > {1'b0, bx1_q});
    assign edge_y = (ly < ({1'b0, by0_q} + LW_L)) || ((ly + LW_L) > {1'b0, by1_q});
    assign hit_d  = valid_q & in_x & in_y & (edge_x | edge_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            line_q       <= 10'd0;
            miss_q       <= 4'd0;
            stat_clear_q <= 1'b0;
            bx0_q        <= 10'd0;
            bx1_q        <= 10'd0;
            by0_q        <= 10'd0;
            by1_q        <= 10'd0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= per_frame_vsync;
            hs_q         <= per_frame_href;
            line_q       <= line_d;
            miss_q       <= miss_d;
            stat_clear_q <= stat_clear_d;
            bx0_q        <= bx0_d;
            bx1_q        <= bx1_d;
            by0_q        <= by0_d;
            by1_q        <= by1_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            hit_q        <= hit_d;
        end
    end

    assign stat_clear = stat_clear_q;
    assign box_x_min  = bx0_q;
    assign box_x_max  = bx1_q;
    assign box_y_min  = by0_q;
    assign box_y_max  = by1_q;
    assign box_valid  = valid_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign box_hit    = hit_q;

endmodule
